// File: rtl/ibex_register_file_fp_sb_pkg.sv
// Shared types and sizing helpers for the FP register file and its scoreboard.
package ibex_fp_pkg;

    // Architectural upper bound on FP registers (full RV32F register space).
    localparam int NumFpRegs = 32;

    // Full-width FP register address as seen on the external buses.
    typedef logic [4:0] fp_reg_addr_t;

    // Number of address bits actually decoded: the E variant halves the file.
    function automatic int addr_width(input bit rv32e);
        return rv32e ? 4 : 5;
    endfunction

    // Number of physically implemented registers for a given variant.
    function automatic int num_regs(input bit rv32e);
        return 32'(1) << addr_width(rv32e);
    endfunction

endpackage

// File: rtl/ibex_register_file_fp_sb_if.sv
// Issue and writeback channel between the FPU and the FP register file.
interface ibex_register_file_fp_sb_if #(
    parameter int DataWidth = 16
);
    logic                       issue_valid_i;
    ibex_fp_pkg::fp_reg_addr_t  issue_rd_i;
    logic                       wb_valid_i;
    ibex_fp_pkg::fp_reg_addr_t  wb_rd_i;
    logic [DataWidth-1:0]       wb_data_i;
    logic                       wb_ready_o;

    // FPU / issue side
    modport master (
        output issue_valid_i, issue_rd_i, wb_valid_i, wb_rd_i, wb_data_i,
        input  wb_ready_o
    );

    // Register file side
    modport slave (
        input  issue_valid_i, issue_rd_i, wb_valid_i, wb_rd_i, wb_data_i,
        output wb_ready_o
    );
endinterface

// File: rtl/ibex_register_file_fp_sb_scoreboard.sv
// Pending-destination tracker: one bit per register plus sticky protocol error.
module ibex_fp_scoreboard
    import ibex_fp_pkg::*;
#(
    parameter bit RV32E      = 1'b0,
    parameter bit ZeroReg    = 1'b0,
    parameter int NumRdPorts = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_i,      // effective issue (reg 0 already filtered)
    input  fp_reg_addr_t            issue_rd_i,
    input  logic                    wb_i,         // effective committed writeback
    input  fp_reg_addr_t            wb_rd_i,
    input  logic                    wea_i,        // effective port-A write
    input  fp_reg_addr_t            wea_addr_i,
    input  logic [NumRdPorts*5-1:0] raddr_i,
    output logic [NumRdPorts-1:0]   busy_o,
    output logic                    err_o
);
    localparam int AW = addr_width(RV32E);
    localparam int NR = num_regs(RV32E);

    logic [AW-1:0] is_idx, wb_idx, wa_idx;
    logic [NR-1:0] pend_q, pend_d;
    // Registers that may still receive a writeback from an op issued before reset.
    logic [NR-1:0] stale_q, stale_d;
    logic          err_q, err_d;

    assign is_idx = issue_rd_i[AW-1:0];
    assign wb_idx = wb_rd_i[AW-1:0];
    assign wa_idx = wea_addr_i[AW-1:0];

    // Next-state: writeback clears, issue sets afterwards so a same-cycle issue wins.
    always_comb begin
        pend_d  = pend_q;
        stale_d = stale_q;
        if (wb_i) begin
            pend_d[wb_idx]  = 1'b0;
            stale_d[wb_idx] = 1'b0;
        end
        if (issue_i) begin
            pend_d[is_idx]  = 1'b1;
            stale_d[is_idx] = 1'b0;
        end
        err_d = err_q
              | (issue_i && pend_q[is_idx])
              | (wb_i && !pend_q[wb_idx] && !stale_q[wb_idx])
              | (wea_i && pend_q[wa_idx]);
    end

    // State registers; reset forgets in-flight ops but tolerates their writebacks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= '0;
            stale_q <= '1;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            stale_q <= stale_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

    for (genvar gi = 0; gi < NumRdPorts; gi++) begin : g_busy
        logic [AW-1:0] ra;
        assign ra = raddr_i[5*gi +: AW];
        // Busy query per read port; register 0 is never busy when hardwired.
        always_comb begin
            busy_o[gi] = pend_q[ra];
            if (ZeroReg && (ra == '0)) busy_o[gi] = 1'b0;
        end
    end
endmodule

// File: rtl/ibex_register_file_fp_sb.sv
// FP register file with immediate and handshaked writeback ports and a scoreboard.
module ibex_register_file_fp_sb
    import ibex_fp_pkg::*;
#(
    parameter bit                RV32E       = 1'b0,
    parameter int                DataWidth   = 16,
    parameter int                NumRdPorts  = 3,
    parameter bit                ZeroReg     = 1'b0,
    parameter bit                Bypass      = 1'b1,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumRdPorts*5-1:0]         fp_raddr_i,
    output logic [NumRdPorts*DataWidth-1:0] fp_rdata_o,
    output logic [NumRdPorts-1:0]           fp_rbusy_o,
    input  fp_reg_addr_t                    fp_waddr_a_i,
    input  logic [DataWidth-1:0]            fp_wdata_a_i,
    input  logic                            fp_we_a_i,
    ibex_register_file_fp_sb_if.slave       fpu_if,
    output logic                            err_o
);
    localparam int AW = addr_width(RV32E);
    localparam int NR = num_regs(RV32E);
    typedef logic [AW-1:0] idx_t;

    logic [DataWidth-1:0] mem_q [NR];

    idx_t                 waddr_a, wb_idx, issue_idx, commit_addr;
    logic                 we_a_eff, wb_commit, wb_eff, issue_eff, commit_en;
    logic [DataWidth-1:0] commit_data;

    assign waddr_a   = fp_waddr_a_i[AW-1:0];
    assign wb_idx    = fpu_if.wb_rd_i[AW-1:0];
    assign issue_idx = fpu_if.issue_rd_i[AW-1:0];

    // A write to a hardwired f0 is not effective and so does not steal the write slot.
    assign we_a_eff  = fp_we_a_i && !(ZeroReg && (waddr_a == '0));
    assign fpu_if.wb_ready_o = !we_a_eff;
    assign wb_commit = fpu_if.wb_valid_i && !we_a_eff;
    assign wb_eff    = wb_commit && !(ZeroReg && (wb_idx == '0));
    assign issue_eff = fpu_if.issue_valid_i && !(ZeroReg && (issue_idx == '0));

    // Single physical write per cycle: port A first, otherwise the accepted writeback.
    always_comb begin
        commit_en   = we_a_eff || wb_eff;
        commit_addr = wb_idx;
        commit_data = fpu_if.wb_data_i;
        if (we_a_eff) begin
            commit_addr = waddr_a;
            commit_data = fp_wdata_a_i;
        end
    end

    // Register storage with reset to the configured word value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NR; r++) mem_q[r] <= WordZeroVal;
        end else if (commit_en) begin
            mem_q[commit_addr] <= commit_data;
        end
    end

    for (genvar gi = 0; gi < NumRdPorts; gi++) begin : g_rd
        idx_t                 ra;
        logic [DataWidth-1:0] rd;
        assign ra = fp_raddr_i[5*gi +: AW];
        // Combinational read with optional forwarding of this cycle's write.
        always_comb begin
            rd = mem_q[ra];
            if (Bypass && commit_en && (commit_addr == ra)) rd = commit_data;
            if (ZeroReg && (ra == '0)) rd = '0;
        end
        assign fp_rdata_o[DataWidth*gi +: DataWidth] = rd;
    end

    ibex_fp_scoreboard #(
        .RV32E      (RV32E),
        .ZeroReg    (ZeroReg),
        .NumRdPorts (NumRdPorts)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .issue_i    (issue_eff),
        .issue_rd_i (fpu_if.issue_rd_i),
        .wb_i       (wb_eff),
        .wb_rd_i    (fpu_if.wb_rd_i),
        .wea_i      (we_a_eff),
        .wea_addr_i (fp_waddr_a_i),
        .raddr_i    (fp_raddr_i),
        .busy_o     (fp_rbusy_o),
        .err_o      (err_o)
    );
endmodule

// File: tb/tb_ibex_register_file_fp_sb.sv
// Directed bench: two configurations driven by the same stimulus.
//   d0: 32 regs, f0 real, bypass on.   d1: 16 regs, f0 hardwired, bypass off.
module tb_ibex_register_file_fp_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] raddr;
    logic [4:0]  waddr_a;
    logic [15:0] wdata_a;
    logic        we_a;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [15:0] wb_data;

    logic [47:0] rdata0, rdata1;
    logic [2:0]  busy0, busy1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_register_file_fp_sb_if #(.DataWidth(16)) if0 ();
    ibex_register_file_fp_sb_if #(.DataWidth(16)) if1 ();

    assign if0.issue_valid_i = issue_valid;
    assign if0.issue_rd_i    = issue_rd;
    assign if0.wb_valid_i    = wb_valid;
    assign if0.wb_rd_i       = wb_rd;
    assign if0.wb_data_i     = wb_data;
    assign if1.issue_valid_i = issue_valid;
    assign if1.issue_rd_i    = issue_rd;
    assign if1.wb_valid_i    = wb_valid;
    assign if1.wb_rd_i       = wb_rd;
    assign if1.wb_data_i     = wb_data;

    ibex_register_file_fp_sb #(
        .RV32E(1'b0), .DataWidth(16), .NumRdPorts(3),
        .ZeroReg(1'b0), .Bypass(1'b1), .WordZeroVal(16'h3C00)
    ) dut0 (
        .clk_i(clk), .rst_i(rst),
        .fp_raddr_i(raddr), .fp_rdata_o(rdata0), .fp_rbusy_o(busy0),
        .fp_waddr_a_i(waddr_a), .fp_wdata_a_i(wdata_a), .fp_we_a_i(we_a),
        .fpu_if(if0), .err_o(err0)
    );

    ibex_register_file_fp_sb #(
        .RV32E(1'b1), .DataWidth(16), .NumRdPorts(3),
        .ZeroReg(1'b1), .Bypass(1'b0), .WordZeroVal(16'h3C00)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .fp_raddr_i(raddr), .fp_rdata_o(rdata1), .fp_rbusy_o(busy1),
        .fp_waddr_a_i(waddr_a), .fp_wdata_a_i(wdata_a), .fp_we_a_i(we_a),
        .fpu_if(if1), .err_o(err1)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-16s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        raddr = {a2, a1, a0};
    endtask

    initial begin
        rst = 1'b1; raddr = '0; waddr_a = '0; wdata_a = '0; we_a = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        @(posedge clk);
        tick();
        rst = 1'b0;

        // Reset state
        set_rd(5'd5, 5'd31, 5'd0); #1;
        check("rst_rd0",   rdata0, {16'h3C00, 16'h3C00, 16'h3C00});
        check("rst_rd1",   rdata1, {16'h0000, 16'h3C00, 16'h3C00});
        check("rst_busy0", busy0, 3'b000);
        check("rst_busy1", busy1, 3'b000);
        check("rst_err",   {err1, err0}, 2'b00);
        check("rst_rdy",   {if1.wb_ready_o, if0.wb_ready_o}, 2'b11);

        // Port A write f3, same-cycle and next-cycle reads (f19 aliases f3 in d1)
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 16'h4200;
        set_rd(5'd3, 5'd19, 5'd3); #1;
        check("wa_byp0", rdata0, {16'h4200, 16'h3C00, 16'h4200});
        check("wa_byp1", rdata1, {16'h3C00, 16'h3C00, 16'h3C00});
        tick();
        we_a = 1'b0; #1;
        check("wa_nxt0", rdata0, {16'h4200, 16'h3C00, 16'h4200});
        check("wa_nxt1", rdata1, {16'h4200, 16'h4200, 16'h4200});

        // Issue f7, then writeback
        issue_valid = 1'b1; issue_rd = 5'd7;
        set_rd(5'd7, 5'd7, 5'd7); #1;
        check("iss_same_busy", {busy1, busy0}, 6'b000000);
        tick();
        issue_valid = 1'b0; #1;
        check("iss_busy", {busy1, busy0}, 6'b111111);
        check("iss_err",  {err1, err0}, 2'b00);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 16'hC000; #1;
        check("wb_rdy",  {if1.wb_ready_o, if0.wb_ready_o}, 2'b11);
        check("wb_byp0", rdata0, {16'hC000, 16'hC000, 16'hC000});
        check("wb_byp1", rdata1, {16'h3C00, 16'h3C00, 16'h3C00});
        tick();
        wb_valid = 1'b0; #1;
        check("wb_busy", {busy1, busy0}, 6'b000000);
        check("wb_rd0",  rdata0, {16'hC000, 16'hC000, 16'hC000});
        check("wb_rd1",  rdata1, {16'hC000, 16'hC000, 16'hC000});
        check("wb_err",  {err1, err0}, 2'b00);

        // Port A and writeback collide: writeback stalls one cycle
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        we_a = 1'b1; waddr_a = 5'd2; wdata_a = 16'h1234;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 16'h5678;
        set_rd(5'd2, 5'd9, 5'd9); #1;
        check("col_rdy",   {if1.wb_ready_o, if0.wb_ready_o}, 2'b00);
        check("col_rd0",   rdata0, {16'h3C00, 16'h3C00, 16'h1234});
        check("col_rd1",   rdata1, {16'h3C00, 16'h3C00, 16'h3C00});
        check("col_busy",  {busy1, busy0}, 6'b110110);
        tick();
        we_a = 1'b0; #1;
        check("col2_rdy",  {if1.wb_ready_o, if0.wb_ready_o}, 2'b11);
        check("col2_rd0",  rdata0, {16'h5678, 16'h5678, 16'h1234});
        check("col2_rd1",  rdata1, {16'h3C00, 16'h3C00, 16'h1234});
        tick();
        wb_valid = 1'b0; #1;
        check("col3_rd0",  rdata0, {16'h5678, 16'h5678, 16'h1234});
        check("col3_rd1",  rdata1, {16'h5678, 16'h5678, 16'h1234});
        check("col3_busy", {busy1, busy0}, 6'b000000);
        check("col3_err",  {err1, err0}, 2'b00);

        // Double issue to f4: sticky error until reset
        issue_valid = 1'b1; issue_rd = 5'd4;
        set_rd(5'd4, 5'd4, 5'd4);
        tick();
        check("dbl_err_a", {err1, err0}, 2'b00);
        check("dbl_busy",  {busy1, busy0}, 6'b111111);
        tick();
        issue_valid = 1'b0; #1;
        check("dbl_err_b", {err1, err0}, 2'b11);
        tick();
        tick();
        check("dbl_hold",  {err1, err0}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("rst2_err",  {err1, err0}, 2'b00);
        check("rst2_busy", {busy1, busy0}, 6'b000000);
        set_rd(5'd4, 5'd3, 5'd9); #1;
        check("rst2_rd0",  rdata0, {16'h3C00, 16'h3C00, 16'h3C00});
        // Late writeback of the op forgotten by reset is accepted silently
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 16'h1111;
        tick();
        wb_valid = 1'b0; #1;
        check("late_err",  {err1, err0}, 2'b00);
        check("late_rd0",  rdata0, {16'h3C00, 16'h3C00, 16'h1111});
        check("late_rd1",  rdata1, {16'h3C00, 16'h3C00, 16'h1111});

        // Register 0 semantics
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 16'hFFFF;
        set_rd(5'd0, 5'd0, 5'd0); #1;
        check("z_rdy",     {if1.wb_ready_o, if0.wb_ready_o}, 2'b10);
        check("z_byp0",    rdata0, {16'hFFFF, 16'hFFFF, 16'hFFFF});
        check("z_byp1",    rdata1, 48'h0);
        tick();
        we_a = 1'b0; #1;
        check("z_rd0",     rdata0, {16'hFFFF, 16'hFFFF, 16'hFFFF});
        check("z_rd1",     rdata1, 48'h0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0; #1;
        check("z_busy",    {busy1, busy0}, 6'b000111);
        check("z_err",     {err1, err0}, 2'b00);
        // Port-A write to a pending register flags only where f0 is real
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 16'hAAAA;
        tick();
        we_a = 1'b0; #1;
        check("z_wa_err",  {err1, err0}, 2'b01);

        // Stray writeback to a register that is no longer pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        set_rd(5'd7, 5'd7, 5'd7);
        tick();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 16'h2222;
        tick();
        wb_valid = 1'b0; #1;
        check("s1_err",    {err1, err0}, 2'b00);
        check("s1_rd",     {rdata1[15:0], rdata0[15:0]}, {16'h2222, 16'h2222});
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 16'h3333;
        tick();
        wb_valid = 1'b0; #1;
        check("s2_err",    {err1, err0}, 2'b11);
        check("s2_rd",     {rdata1[15:0], rdata0[15:0]}, {16'h3333, 16'h3333});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibex_register_file_fp_sb.md
Name: ibex_register_file_fp_sb

Overview:
Parametrised FP register file with an integrated scoreboard, and the successor to the current single-write FP regfile. Configurable read-port count (3 for FMA), depth, data width and register-0 semantics. Two write ports: an immediate port for loads/moves, and a handshaked writeback port for long-latency FPU results. Tracks pending destinations so the ID stage can stall on RAW/WAW hazards. Sits between ibex ID stage, LSU and the FPU.

Parameters:
RV32E, 0, 1 = 16 registers, 0 = 32 registers
DataWidth, 16, register width in bits
NumRdPorts, 3, number of read ports (2..3)
ZeroReg, 0, 1 = register 0 reads zero and ignores writes; 0 = f0 is a real register
Bypass, 1, 1 = same-cycle write data forwarded to reads
WordZeroVal, '0, reset value of every register

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
fp_raddr_i  in  NumRdPorts*5  read addresses, port k at bits [5k+4:5k]
fp_rdata_o  out  NumRdPorts*DataWidth  read data, packed the same way
fp_rbusy_o  out  NumRdPorts  read register has a pending FPU write
fp_waddr_a_i  in  5  immediate write address
fp_wdata_a_i  in  DataWidth  immediate write data
fp_we_a_i  in  1  immediate write enable
issue_valid_i  in  1  FPU op issued; marks issue_rd_i pending
issue_rd_i  in  5  destination of the issued op
wb_valid_i  in  1  FPU result valid
wb_rd_i  in  5  FPU result destination
wb_data_i  in  DataWidth  FPU result data
wb_ready_o  out  1  writeback accepted this cycle
err_o  out  1  sticky protocol-error flag

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at posedge): all registers = WordZeroVal; all pending bits = 0; err_o = 0. Reset overrides any write, issue or writeback in the same cycle. An in-flight FPU op is forgotten, and its later writeback is accepted without error.
- Address bits above ADDR_WIDTH (bit 4 when RV32E=1) are ignored.
- Reads are combinational. A write at posedge N is visible from cycle N+1.
- Bypass=1: if a read address matches the write being committed this cycle, the write data is returned. Port A takes priority over port B.
- ZeroReg=1: address 0 reads '0. Writes, issues and writebacks to register 0 have no effect on storage or scoreboard.
- Port arbitration: one physical write per cycle.
  - wb_ready_o = !(fp_we_a_i && write is effective).
  - A writeback commits when wb_valid_i && wb_ready_o.
  - While wb_valid_i is high and wb_ready_o is low, wb_rd_i and wb_data_i must stay stable.
- Scoreboard: one pending bit per register.
  - Set at the edge after issue_valid_i.
  - Cleared at the edge of a committed writeback.
  - Same-cycle issue and writeback to the same register: the bit stays set (the new issue wins).
- fp_rbusy_o[k] = pending[raddr_k], and 0 for register 0 when ZeroReg=1. It does not reflect the same-cycle issue.
- err_o is set, and held until reset, on any of:
  - issue to an already-pending register;
  - committed writeback to a non-pending register (except after reset);
  - port-A write to a pending register.
  The offending write or issue is still performed.

Decomposition:
- Shared package ibex_fp_pkg: ADDR_WIDTH function of RV32E, fp_reg_addr_t typedef, NumFpRegs constant.
- One sub-module, ibex_fp_scoreboard: pending-bit array with set/clear/query logic and the error conditions.
- Storage, arbitration and bypass stay in the top module.

Test Plan:
- Reset with WordZeroVal=16'h3C00, then read f5 and f31 -> both 16'h3C00, all fp_rbusy_o=0, err_o=0.
- Port A writes f3=16'h4200 at cycle N; read f3 the same cycle -> 16'h4200 with Bypass=1, old value with Bypass=0; cycle N+1 -> 16'h4200.
- Issue rd=7; next cycle read f7 -> busy=1; writeback f7=16'hC000 with ready -> next cycle busy=0 and data 16'hC000, err_o=0.
- Port A write f2 and wb_valid_i for f9 in the same cycle -> wb_ready_o=0 and f9 unchanged; next cycle wb_ready_o=1 and f9 is written.
- Issue rd=4 twice without writeback -> err_o=1 and stays 1 until rst_i; after rst_i, err_o=0 and busy(f4)=0.
- ZeroReg=1: write f0=16'hFFFF, then read f0 -> 16'h0000; issue rd=0 -> busy=0, err_o=0.
